// File: rtl/stream_demux_pkg.sv
// Shared definitions for the packet stream demultiplexer: steering modes and FSM encoding.
package stream_demux_pkg;

  localparam int unsigned MODE_SEL = 0;
  localparam int unsigned MODE_RR  = 1;

  typedef enum logic {
    StIdle = 1'b0,
    StPkt  = 1'b1
  } state_e;

endpackage

// File: rtl/stream_demux_oreg.sv
// Output holding register for the demux: one slot of {data, last, ch, valid} with
// simultaneous load/drain support.
module stream_demux_oreg #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic [SEL_W-1:0]  ch_i,
  input  logic              drain_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic [SEL_W-1:0]  ch_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic [SEL_W-1:0]  ch_q, ch_d;

  // Slot is free when empty or when its current beat leaves this cycle.
  assign ready_o = !valid_q || drain_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    ch_d    = ch_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
      ch_d    = ch_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      ch_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      ch_q    <= ch_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign ch_o    = ch_q;

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N_CH packet demultiplexer. The destination is locked on the first beat and
// held until the last beat; select-steered or round-robin, with out-of-range packets dropped.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_CH   = 4,
  parameter int unsigned MODE   = MODE_SEL,
  parameter int unsigned CNT_W  = 8,
  localparam int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic [SEL_W-1:0]  i_sel,
  output logic [N_CH-1:0]   op_valid,
  input  logic [N_CH-1:0]   op_ready,
  output logic [DATA_W-1:0] op_data,
  output logic              op_last,
  output logic [SEL_W-1:0]  op_ch,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam logic [SEL_W:0]   NChExt = (SEL_W + 1)'(N_CH);
  localparam logic [SEL_W-1:0] LastCh = SEL_W'(N_CH - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  lock_ch_q, lock_ch_d;
  logic              drop_q, drop_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic              out_valid;
  logic [SEL_W-1:0]  out_ch;
  logic              drain;
  logic              accept;
  logic              load;
  logic [SEL_W-1:0]  first_ch, cur_ch;
  logic              first_drop, cur_drop;

  always_comb begin
    op_valid = '0;
    for (int k = 0; k < N_CH; k++) begin
      op_valid[k] = out_valid && (out_ch == SEL_W'(k));
    end
  end

  // Equivalent to op_ready[out_ch] but never indexes past N_CH-1.
  assign drain  = |(op_valid & op_ready);
  assign accept = i_valid && i_ready;

  always_comb begin
    first_ch   = (MODE == MODE_RR) ? rr_ptr_q : i_sel;
    first_drop = (MODE == MODE_SEL) && ({1'b0, i_sel} >= NChExt);
    cur_ch     = (state_q == StPkt) ? lock_ch_q : first_ch;
    cur_drop   = (state_q == StPkt) ? drop_q : first_drop;
    load       = accept && !cur_drop;
  end

  always_comb begin
    state_d    = state_q;
    lock_ch_d  = lock_ch_q;
    drop_d     = drop_q;
    rr_ptr_d   = rr_ptr_q;
    drop_cnt_d = drop_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (accept && !i_last) begin
          state_d   = StPkt;
          lock_ch_d = first_ch;
          drop_d    = first_drop;
        end
      end
      StPkt: begin
        if (accept && i_last) begin
          state_d = StIdle;
          drop_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept && i_last) begin
      rr_ptr_d = (rr_ptr_q == LastCh) ? '0 : rr_ptr_q + SEL_W'(1);
    end

    if (accept && cur_drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      lock_ch_q  <= '0;
      drop_q     <= 1'b0;
      rr_ptr_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_ch_q  <= lock_ch_d;
      drop_q     <= drop_d;
      rr_ptr_q   <= rr_ptr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  stream_demux_oreg #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_oreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .data_i  (i_data),
    .last_i  (i_last),
    .ch_i    (cur_ch),
    .drain_i (drain),
    .ready_o (i_ready),
    .valid_o (out_valid),
    .data_o  (op_data),
    .last_o  (op_last),
    .ch_o    (out_ch)
  );

  assign op_ch    = out_ch;
  assign busy     = (state_q == StPkt);
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: select-steered N_CH=4 (a_*), round-robin N_CH=3 (b_*),
// select-steered N_CH=3 with out-of-range drops (c_*).
module tb_stream_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_bc;
  int   n_tests, n_fail;

  logic       a_i_valid, a_i_ready, a_i_last, a_op_last, a_busy;
  logic [7:0] a_i_data, a_op_data, a_drop_cnt;
  logic [1:0] a_i_sel, a_op_ch;
  logic [3:0] a_op_valid, a_op_ready;

  logic       b_i_valid, b_i_ready, b_i_last, b_op_last, b_busy;
  logic [7:0] b_i_data, b_op_data, b_drop_cnt;
  logic [1:0] b_i_sel, b_op_ch;
  logic [2:0] b_op_valid, b_op_ready;

  logic       c_i_valid, c_i_ready, c_i_last, c_op_last, c_busy;
  logic [7:0] c_i_data, c_op_data, c_drop_cnt;
  logic [1:0] c_i_sel, c_op_ch;
  logic [2:0] c_op_valid, c_op_ready;

  stream_demux #(.DATA_W(8), .N_CH(4), .MODE(0), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_a), .i_valid(a_i_valid), .i_ready(a_i_ready), .i_data(a_i_data),
    .i_last(a_i_last), .i_sel(a_i_sel), .op_valid(a_op_valid), .op_ready(a_op_ready),
    .op_data(a_op_data), .op_last(a_op_last), .op_ch(a_op_ch), .busy(a_busy),
    .drop_cnt(a_drop_cnt)
  );

  stream_demux #(.DATA_W(8), .N_CH(3), .MODE(1), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_bc), .i_valid(b_i_valid), .i_ready(b_i_ready), .i_data(b_i_data),
    .i_last(b_i_last), .i_sel(b_i_sel), .op_valid(b_op_valid), .op_ready(b_op_ready),
    .op_data(b_op_data), .op_last(b_op_last), .op_ch(b_op_ch), .busy(b_busy),
    .drop_cnt(b_drop_cnt)
  );

  stream_demux #(.DATA_W(8), .N_CH(3), .MODE(0), .CNT_W(8)) u_dut_c (
    .clk(clk), .rst_n(rst_bc), .i_valid(c_i_valid), .i_ready(c_i_ready), .i_data(c_i_data),
    .i_last(c_i_last), .i_sel(c_i_sel), .op_valid(c_op_valid), .op_ready(c_op_ready),
    .op_data(c_op_data), .op_last(c_op_last), .op_ch(c_op_ch), .busy(c_busy),
    .drop_cnt(c_drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [1:0] s, input logic [7:0] d,
                         input logic l);
    a_i_valid = v;
    a_i_sel   = s;
    a_i_data  = d;
    a_i_last  = l;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_a   = 1'b0;
    rst_bc  = 1'b0;
    drive_a(1'b0, 2'd0, 8'h00, 1'b0);
    a_op_ready = 4'hF;
    b_i_valid = 1'b0; b_i_sel = 2'd0; b_i_data = 8'h00; b_i_last = 1'b0; b_op_ready = 3'b111;
    c_i_valid = 1'b0; c_i_sel = 2'd0; c_i_data = 8'h00; c_i_last = 1'b0; c_op_ready = 3'b111;

    #12;
    check("rst op_valid", a_op_valid, 4'b0000);
    check("rst op_data", a_op_data, 8'h00);
    check("rst op_last", a_op_last, 1'b0);
    check("rst op_ch", a_op_ch, 2'd0);
    check("rst busy", a_busy, 1'b0);
    check("rst drop_cnt", a_drop_cnt, 8'd0);
    check("rst i_ready", a_i_ready, 1'b1);
    rst_a  = 1'b1;
    rst_bc = 1'b1;
    tick();

    // Single-beat packets to each channel.
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 2'(i), 8'hA0 + 8'(i), 1'b1);
      #1;
      check("single i_ready", a_i_ready, 1'b1);
      tick();
      check("single op_valid", a_op_valid, 32'(1) << i);
      check("single op_data", a_op_data, 8'hA0 + 8'(i));
      check("single op_ch", a_op_ch, i);
    end
    drive_a(1'b0, 2'd0, 8'h00, 1'b0);
    tick();
    check("idle op_valid", a_op_valid, 4'b0000);

    // 3-beat packet locked to channel 2 although i_sel changes.
    drive_a(1'b1, 2'd2, 8'h10, 1'b0);
    tick();
    check("pkt b0 op_valid", a_op_valid, 4'b0100);
    check("pkt b0 busy", a_busy, 1'b1);
    check("pkt b0 op_last", a_op_last, 1'b0);
    drive_a(1'b1, 2'd1, 8'h11, 1'b0);
    tick();
    check("pkt b1 op_valid", a_op_valid, 4'b0100);
    check("pkt b1 op_data", a_op_data, 8'h11);
    check("pkt b1 busy", a_busy, 1'b1);
    check("pkt b1 op_last", a_op_last, 1'b0);
    drive_a(1'b1, 2'd1, 8'h12, 1'b1);
    tick();
    check("pkt b2 op_valid", a_op_valid, 4'b0100);
    check("pkt b2 op_data", a_op_data, 8'h12);
    check("pkt b2 op_last", a_op_last, 1'b1);
    check("pkt b2 busy", a_busy, 1'b0);
    drive_a(1'b0, 2'd0, 8'h00, 1'b0);
    tick();

    // Backpressure on channel 1.
    a_op_ready = 4'b1101;
    drive_a(1'b1, 2'd1, 8'h20, 1'b0);
    #1;
    check("bp first i_ready", a_i_ready, 1'b1);
    tick();
    drive_a(1'b1, 2'd3, 8'h21, 1'b1);
    for (int c = 0; c < 4; c++) begin
      #1;
      check("bp i_ready", a_i_ready, 1'b0);
      check("bp op_data", a_op_data, 8'h20);
      check("bp op_valid", a_op_valid, 4'b0010);
      check("bp busy", a_busy, 1'b1);
      tick();
    end
    a_op_ready = 4'hF;
    #1;
    check("bp release i_ready", a_i_ready, 1'b1);
    tick();
    check("bp last op_valid", a_op_valid, 4'b0010);
    check("bp last op_data", a_op_data, 8'h21);
    check("bp last op_last", a_op_last, 1'b1);
    check("bp last busy", a_busy, 1'b0);
    drive_a(1'b0, 2'd0, 8'h00, 1'b0);
    tick();
    check("bp drained", a_op_valid, 4'b0000);

    // Asynchronous reset mid-packet.
    drive_a(1'b1, 2'd2, 8'h30, 1'b0);
    tick();
    check("mid busy", a_busy, 1'b1);
    check("mid op_valid", a_op_valid, 4'b0100);
    #2;
    rst_a = 1'b0;
    #1;
    check("async rst op_valid", a_op_valid, 4'b0000);
    check("async rst busy", a_busy, 1'b0);
    check("async rst drop_cnt", a_drop_cnt, 8'd0);
    check("async rst op_data", a_op_data, 8'h00);
    drive_a(1'b0, 2'd0, 8'h00, 1'b0);
    #2;
    rst_a = 1'b1;
    tick();
    check("post rst op_valid", a_op_valid, 4'b0000);
    check("post rst busy", a_busy, 1'b0);
    drive_a(1'b1, 2'd0, 8'h40, 1'b1);
    tick();
    check("post rst route", a_op_valid, 4'b0001);
    check("post rst data", a_op_data, 8'h40);
    drive_a(1'b0, 2'd0, 8'h00, 1'b0);
    tick();

    // Round-robin, N_CH=3: five 2-beat packets, i_sel varied and ignored.
    for (int p = 0; p < 5; p++) begin
      b_i_valid = 1'b1;
      b_i_sel   = 2'(p) ^ 2'b11;
      b_i_data  = 8'h50 + 8'(2 * p);
      b_i_last  = 1'b0;
      tick();
      check("rr b0 op_ch", b_op_ch, p % 3);
      check("rr b0 op_valid", b_op_valid, 32'(1) << (p % 3));
      b_i_sel  = 2'(p + 1);
      b_i_data = 8'h51 + 8'(2 * p);
      b_i_last = 1'b1;
      tick();
      check("rr b1 op_ch", b_op_ch, p % 3);
      check("rr b1 op_last", b_op_last, 1'b1);
      check("rr b1 op_data", b_op_data, 8'h51 + 8'(2 * p));
    end
    b_i_valid = 1'b0;
    tick();

    // Out-of-range select, N_CH=3: whole 4-beat packet dropped.
    for (int b = 0; b < 4; b++) begin
      c_i_valid = 1'b1;
      c_i_sel   = (b == 0) ? 2'd3 : 2'd0;
      c_i_data  = 8'h60 + 8'(b);
      c_i_last  = (b == 3);
      #1;
      check("drop i_ready", c_i_ready, 1'b1);
      tick();
      check("drop op_valid", c_op_valid, 3'b000);
      check("drop cnt", c_drop_cnt, b + 1);
      check("drop busy", c_busy, (b != 3));
    end
    c_i_sel  = 2'd3;
    c_i_last = 1'b1;
    repeat (300) tick();
    check("drop saturate", c_drop_cnt, 8'd255);
    check("drop sat op_valid", c_op_valid, 3'b000);
    c_i_sel  = 2'd1;
    c_i_data = 8'h55;
    tick();
    check("after drop route", c_op_valid, 3'b010);
    check("after drop data", c_op_data, 8'h55);
    check("after drop cnt", c_drop_cnt, 8'd255);
    c_i_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
